// File: rtl/cordic_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_rr_arbiter
// Purpose  : Round-robin arbiter that shares one fully pipelined CORDIC atan
//            core between N_REQ (x, y) requesters. The winning sample is
//            registered into the core, and its requester index travels down a
//            delay line matched to the core latency. The core's output valid
//            is compared against that tracked schedule, and any disagreement
//            raises a sticky error.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            en                    - grant enable (in-flight samples still drain)
//            req_valid/x/y         - per-requester samples, packed by index
//            req_ready             - one-hot-or-zero combinational grant
//            cordic_x/y/valid      - registered core input
//            cordic_dout_valid     - core output valid
//            res_valid/res_id      - tracked result valid and requester tag
//            err                   - sticky schedule mismatch
// Revision : 1.0 - initial release
// ============================================================================
module cordic_rr_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DIN_WIDTH      = 16,
  parameter int CORDIC_LATENCY = 16,
  parameter int ID_WIDTH       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DIN_WIDTH-1:0] req_x,
  input  logic [N_REQ*DIN_WIDTH-1:0] req_y,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DIN_WIDTH-1:0]       cordic_x,
  output logic [DIN_WIDTH-1:0]       cordic_y,
  output logic                       cordic_valid,
  input  logic                       cordic_dout_valid,
  output logic                       res_valid,
  output logic [ID_WIDTH-1:0]        res_id,
  output logic                       err
);

  localparam int                  MASK_W    = $clog2(CORDIC_LATENCY + 2);
  localparam logic [MASK_W-1:0]   MASK_INIT = MASK_W'(CORDIC_LATENCY + 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(N_REQ - 1);

  logic [ID_WIDTH-1:0]  ptr;
  logic [ID_WIDTH-1:0]  grant_id;
  logic                 found;
  logic                 xfer;
  logic [DIN_WIDTH-1:0] sel_x;
  logic [DIN_WIDTH-1:0] sel_y;

  // Tag of the sample currently held in the core input registers; it is the
  // head of the ID delay line and loads together with cordic_x/cordic_y.
  logic [ID_WIDTH-1:0]  cordic_id;

  logic [CORDIC_LATENCY-1:0] pipe_v;
  logic [ID_WIDTH-1:0]       pipe_id [CORDIC_LATENCY];
  logic [MASK_W-1:0]         mask_cnt;

  // --------------------------------------------------------------------------
  // Grant search. The first pass covers indices ptr..N_REQ-1; the second pass
  // only matters when nothing at or above ptr is valid, so it effectively
  // covers 0..ptr-1 and completes the circular order without modulo
  // arithmetic on a non-power-of-two ring.
  // --------------------------------------------------------------------------
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (ID_WIDTH'(i) >= ptr)) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(i);
      end
    end

    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_x = req_x[i*DIN_WIDTH +: DIN_WIDTH];
        sel_y = req_y[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  // The winner is always a valid requester, so ready implies valid.
  assign xfer = en & found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = xfer && (grant_id == ID_WIDTH'(gi));
  end

  // --------------------------------------------------------------------------
  // Core input registers and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cordic_x     <= '0;
      cordic_y     <= '0;
      cordic_valid <= 1'b0;
      cordic_id    <= '0;
      ptr          <= '0;
    end else begin
      cordic_valid <= xfer;
      if (xfer) begin
        cordic_x  <= sel_x;
        cordic_y  <= sel_y;
        cordic_id <= grant_id;
        ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // ID delay line. Ids only advance alongside a valid bit, so every stage
  // keeps the last tag that passed through it, and res_id holds while
  // res_valid is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int k = 0; k < CORDIC_LATENCY; k++) begin
        pipe_id[k] <= '0;
      end
    end else begin
      pipe_v[0] <= cordic_valid;
      if (cordic_valid) begin
        pipe_id[0] <= cordic_id;
      end
      for (int k = 1; k < CORDIC_LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        if (pipe_v[k-1]) begin
          pipe_id[k] <= pipe_id[k-1];
        end
      end
    end
  end

  assign res_valid = pipe_v[CORDIC_LATENCY-1];
  assign res_id    = pipe_id[CORDIC_LATENCY-1];

  // --------------------------------------------------------------------------
  // Schedule check. After reset the core may still flush samples issued
  // before reset, so checking is held off until the mask counter drains.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_cnt <= MASK_INIT;
      err      <= 1'b0;
    end else begin
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - MASK_W'(1);
      end else if (cordic_dout_valid != res_valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_rr_arbiter
// Purpose  : Self-checking bench for cordic_rr_arbiter. A reference grant
//            model predicts req_ready, a scoreboard carries expected core
//            inputs and result tags, and a simple delay-line model stands in
//            for the CORDIC core's output valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int L  = 16;
  localparam int N3 = 3;
  localparam int W3 = 8;
  localparam int L3 = 2;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   cordic_x;
  logic [W-1:0]   cordic_y;
  logic           cordic_valid;
  logic           cordic_dout_valid;
  logic           res_valid;
  logic [1:0]     res_id;
  logic           err;

  logic             en3;
  logic [N3-1:0]    req_valid3;
  logic [N3*W3-1:0] req_x3;
  logic [N3*W3-1:0] req_y3;
  logic [N3-1:0]    req_ready3;
  logic [W3-1:0]    cordic_x3;
  logic [W3-1:0]    cordic_y3;
  logic             cordic_valid3;
  logic             cordic_dout_valid3;
  logic             res_valid3;
  logic [1:0]       res_id3;
  logic             err3;

  // Core stand-ins: delay cordic_valid by the core latency. They are never
  // reset, so samples in flight at reset come out afterwards as stale outputs.
  logic [L-1:0]  core_sr  = '0;
  logic [L3-1:0] core3_sr = '0;
  logic          inject;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mptr     = 0;
  logic [L:0]  hist     = '0;
  logic        exp_err  = 1'b0;
  logic [N-1:0]  last_ready;
  logic [N3-1:0] last_ready3;
  logic [31:0] q_in [$];
  logic [1:0]  q_id [$];

  cordic_rr_arbiter #(.N_REQ(N), .DIN_WIDTH(W), .CORDIC_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_x(req_x),
    .req_y(req_y), .req_ready(req_ready), .cordic_x(cordic_x),
    .cordic_y(cordic_y), .cordic_valid(cordic_valid),
    .cordic_dout_valid(cordic_dout_valid), .res_valid(res_valid),
    .res_id(res_id), .err(err)
  );

  cordic_rr_arbiter #(.N_REQ(N3), .DIN_WIDTH(W3), .CORDIC_LATENCY(L3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .req_valid(req_valid3), .req_x(req_x3),
    .req_y(req_y3), .req_ready(req_ready3), .cordic_x(cordic_x3),
    .cordic_y(cordic_y3), .cordic_valid(cordic_valid3),
    .cordic_dout_valid(cordic_dout_valid3), .res_valid(res_valid3),
    .res_id(res_id3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    core_sr  <= {core_sr[L-2:0], cordic_valid};
    core3_sr <= {core3_sr[L3-2:0], cordic_valid3};
  end
  assign cordic_dout_valid  = core_sr[L-1] | inject;
  assign cordic_dout_valid3 = core3_sr[L3-1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    int          w;
    logic [N-1:0] eg;
    logic [31:0] e;
    logic [1:0]  eid;
    #1;
    w  = -1;
    eg = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        int i = (mptr + k) % N;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    last_ready  = req_ready;
    last_ready3 = req_ready3;
    check("req_ready", req_ready, eg);
    if (w >= 0) begin
      q_in.push_back({req_x[w*W +: W], req_y[w*W +: W]});
      q_id.push_back(2'(w));
      mptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    hist = {hist[L-1:0], (w >= 0)};
    check("cordic_valid", cordic_valid, hist[0]);
    if (cordic_valid) begin
      if (q_in.size() == 0) begin
        n_assert++; n_fail++;
        $error("FAIL cordic_in_queue observed=extra_sample expected=none");
      end else begin
        e = q_in.pop_front();
        check("cordic_x", cordic_x, e[31:16]);
        check("cordic_y", cordic_y, e[15:0]);
      end
    end
    check("res_valid", res_valid, hist[L]);
    if (res_valid) begin
      if (q_id.size() == 0) begin
        n_assert++; n_fail++;
        $error("FAIL res_queue observed=extra_result expected=none");
      end else begin
        eid = q_id.pop_front();
        check("res_id", res_id, eid);
      end
    end
    check("err", err, exp_err);
  endtask

  initial begin
    logic [N-1:0]  eg1;
    logic [N3-1:0] eg3;
    logic [N-1:0]  wrap_exp [3];

    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    inject = 1'b0; en3 = 1'b0; req_valid3 = '0; req_x3 = '0; req_y3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cordic_x", cordic_x, 0);
    check("rst_cordic_y", cordic_y, 0);
    check("rst_cordic_valid", cordic_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_err", err, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Full contention from ptr=0: strict 0,1,2,3 rotation.
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        req_x[i*W +: W] = W'(k * 16 + i);
        req_y[i*W +: W] = W'(16'h8000 + k * 16 + i);
      end
      eg1 = 4'b0001 << (k % 4);
      tick();
      check("contention_grant", last_ready, eg1);
    end
    req_valid = '0;
    repeat (L + 2) tick();

    // Single requester 2, x = 1..5.
    req_valid = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      req_x[2*W +: W] = W'(k);
      req_y[2*W +: W] = W'(100 + k);
      tick();
      check("single_grant", last_ready, 4'b0100);
    end
    req_valid = '0;
    repeat (L + 2) tick();

    // Wrap and skip: ptr is 3 now, only 0 and 2 requesting.
    wrap_exp[0] = 4'b0001; wrap_exp[1] = 4'b0100; wrap_exp[2] = 4'b0001;
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      req_x[0 +: W] = W'(16'h0A00 + k); req_x[2*W +: W] = W'(16'h0C00 + k);
      tick();
      check("wrap_grant", last_ready, wrap_exp[k]);
    end

    // en gating: two grants, three blocked cycles, then rotation resumes.
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      en = !(k >= 2 && k < 5);
      for (int i = 0; i < N; i++) req_x[i*W +: W] = W'(16'h5000 + k * 16 + i);
      tick();
      if (!en) check("en_low_ready", last_ready, 0);
    end
    en = 1'b1;
    req_valid = '0;
    repeat (L + 2) tick();
    check("q_in_drained", q_in.size(), 0);
    check("q_id_drained", q_id.size(), 0);

    // Non-power-of-two instance: grants 0,1,2,0.
    en3 = 1'b1;
    req_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      eg3 = 3'b001 << (k % 3);
      tick();
      check("n3_grant", last_ready3, eg3);
    end
    req_valid3 = '0;
    repeat (L3 + 3) tick();
    check("n3_err", err3, 0);

    // Error injection: core valid with nothing tracked.
    inject  = 1'b1;
    exp_err = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();

    // Mid-stream reset.
    req_valid = 4'b1111;
    repeat (6) tick();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("midrst_cordic_x", cordic_x, 0);
    check("midrst_cordic_y", cordic_y, 0);
    check("midrst_cordic_valid", cordic_valid, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_id", res_id, 0);
    check("midrst_err", err, 0);
    q_in.delete(); q_id.delete();
    hist = '0; mptr = 0; exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stale core outputs and injected pulses inside the mask window are
    // ignored; the first checked edge after the window does flag.
    for (int t = 1; t <= 20; t++) begin
      inject = (t == 3 || t == 17 || t == 18);
      if (t == 18) exp_err = 1'b1;
      tick();
    end
    inject = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_rr_arbiter.md
# cordic_rr_arbiter

Round-robin arbiter sharing one fully pipelined CORDIC atan core between N_REQ independent (x, y) requesters. Grants at most one requester per cycle and registers the winning sample into the core. Tags each core output with its requester index through an internal ID delay line of matching latency. Reports a sticky error if the core's output valid ever disagrees with the tracked in-flight schedule.

## Interface
- N_REQ, 4: number of requesters; any value ≥2, not necessarily a power of two
- DIN_WIDTH, 16: width of each x and y sample
- CORDIC_LATENCY, 16: cycles from core input valid to core output valid; ≥1
- ID_WIDTH, $clog2(N_REQ): requester index width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  grant enable; 0 blocks new grants, in-flight samples still drain
- req_valid  in  N_REQ  per-requester sample valid
- req_x  in  N_REQ*DIN_WIDTH  packed x samples, requester i at bits [i*DIN_WIDTH +: DIN_WIDTH]
- req_y  in  N_REQ*DIN_WIDTH  packed y samples, same packing
- req_ready  out  N_REQ  one-hot-or-zero grant, combinational
- cordic_x  out  DIN_WIDTH  registered x to core
- cordic_y  out  DIN_WIDTH  registered y to core
- cordic_valid  out  1  registered input valid to core
- cordic_dout_valid  in  1  output valid from core
- res_valid  out  1  tracked result valid, aligned with core output
- res_id  out  ID_WIDTH  requester index of the current core output
- err  out  1  sticky schedule mismatch

## Operation
- Pointer ptr (ID_WIDTH bits) holds the highest-priority index. Reset value 0.
- Grant search: first i in ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 with req_valid[i]=1. The winner gets req_ready[i]=1 when en=1. All other bits are 0.
- req_ready is a pure function of req_valid, ptr and en. It must not depend on any other input. No grant when en=0 or req_valid=0.
- Transfer on req_valid[i] & req_ready[i]. On the next edge:
  - cordic_x/cordic_y take requester i's slice.
  - cordic_valid=1.
  - ptr = i+1, wrapping N_REQ-1 → 0.
- No transfer: cordic_valid=0. cordic_x/cordic_y hold their previous values. ptr holds.
- ID delay line: CORDIC_LATENCY stages of {valid, id}. Stage 0 loads {cordic_valid, granted id} alongside the core input registers. The last stage drives res_valid/res_id. res_id holds its last value when res_valid=0.
- Error check, each cycle: if cordic_dout_valid ≠ res_valid, set err. err stays 1 until reset.
- Reset mask: a counter loaded to CORDIC_LATENCY+1 on reset. It decrements each cycle after rst_n deasserts. Error checking is disabled while the counter is nonzero, so stale core outputs from before reset are ignored.
- Requesters need not hold samples after a grant. A requester with req_valid held high is regranted only after every other active requester has been served once.

## Timing
- Reset (async assert, sync deassert by the system): cordic_x=0, cordic_y=0, cordic_valid=0, res_valid=0, res_id=0, err=0, ptr=0, delay line all 0, mask counter=CORDIC_LATENCY+1.
- Grant to core input: handshake in cycle t → cordic_valid=1 in cycle t+1.
- Core input to tag: cordic_valid in cycle t+1 → res_valid/res_id in cycle t+1+CORDIC_LATENCY.
- Throughput: one sample per cycle with no bubbles when any req_valid is high and en=1.
- Fairness: with all N_REQ requesters continuously valid, grants repeat 0,1,…,N_REQ-1,0…. Each requester waits at most N_REQ-1 cycles.
- en low mid-stream: grants stop the same cycle. Tags already in the delay line still emerge on schedule.
- rst_n asserted mid-operation: all in-flight tags are discarded immediately. err is not set by the core's stale outputs during the mask window.

## Test plan
- Single requester: N_REQ=4, CORDIC_LATENCY=16, only req_valid[2] held high for 5 cycles with x=1..5 → cordic_valid high for 5 consecutive cycles with x=1..5. res_valid high 16 cycles later for 5 cycles, res_id=2. err=0.
- Full contention: all req_valid high for 12 cycles → grant order 0,1,2,3,0,1,2,3,0,1,2,3. Each req_ready is one-hot. res_id shows the same sequence 16 cycles later.
- Wrap and skip: ptr=3 with req_valid=4'b0101 → grant 0 then 2 then 0. ptr goes 3→1→3→1.
- Non-power-of-two: N_REQ=3, all valid → grants 0,1,2,0. ptr never reaches 3.
- en gating: all valid, en dropped for 3 cycles → req_ready=0 and cordic_valid=0 for exactly those 3 cycles (plus 1 cycle registered delay). Round-robin order resumes from the saved ptr.
- Errors and reset: inject cordic_dout_valid=1 with res_valid=0 → err=1 next cycle and stays 1. Assert rst_n=0 mid-stream → all outputs 0. Core pulses cordic_dout_valid within 17 cycles after deassert → err stays 0.
